// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : oversampled, majority-voted UART receiver feeding an
//                error-flagged first-word-fall-through receive FIFO
// Revision     : 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int OVS         = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          bclk,
    input  logic                          rxd,
    input  logic                          rx_en,
    input  logic                          read_en,
    input  logic                          parity_en,
    input  logic                          parity_type,
    input  logic [1:0]                    data_len,
    input  logic                          stop2,
    input  logic [1:0]                    rx_thr_val,
    output logic [7:0]                    data_out,
    output logic                          rx_fre,
    output logic                          rx_pe,
    output logic                          rx_brk,
    output logic                          rx_ov,
    output logic                          rx_thr,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          rx_bclk_en
);

    localparam int TW = $clog2(OVS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] c_tick_s0   = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] c_tick_s1   = TW'(OVS/2);
    localparam logic [TW-1:0] c_tick_s2   = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] c_tick_last = TW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_BRKWAIT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bits_q, bits_d;
    logic [7:0]             data_q, data_d;
    logic [1:0]             samp_q, samp_d;
    logic                   seen1_q, seen1_d;
    logic                   pe_q, pe_d;
    logic                   fre_q, fre_d;
    logic                   stopn_q, stopn_d;

    logic                   w_rxd, w_vote, w_mid, w_end;
    logic                   w_push;
    logic [10:0]            w_push_entry;

    assign w_rxd = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bits_q  <= '0;
            data_q  <= '0;
            samp_q  <= '0;
            seen1_q <= 1'b0;
            pe_q    <= 1'b0;
            fre_q   <= 1'b0;
            stopn_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
            if (bclk) begin
                prev_q <= w_rxd;
            end
            state_q <= state_d;
            tick_q  <= tick_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
            samp_q  <= samp_d;
            seen1_q <= seen1_d;
            pe_q    <= pe_d;
            fre_q   <= fre_d;
            stopn_q <= stopn_d;
        end
    end

    // Third vote sample is the live synced line, so every decision lands on tick OVS/2+1.
    assign w_vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & w_rxd) | (samp_q[0] & w_rxd);
    assign w_mid  = bclk && (tick_q == c_tick_s2);
    assign w_end  = bclk && (tick_q == c_tick_last);

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bits_d       = bits_q;
        data_d       = data_q;
        samp_d       = samp_q;
        seen1_d      = seen1_q;
        pe_d         = pe_q;
        fre_d        = fre_q;
        stopn_d      = stopn_q;
        w_push       = 1'b0;
        w_push_entry = '0;

        if (bclk && state_q != S_IDLE && state_q != S_BRKWAIT) begin
            tick_d = w_end ? '0 : tick_q + TW'(1);
            if (tick_q == c_tick_s0) samp_d[0] = w_rxd;
            if (tick_q == c_tick_s1) samp_d[1] = w_rxd;
        end

        case (state_q)
            S_IDLE: begin
                if (bclk && rx_en && prev_q && !w_rxd) begin
                    state_d = S_START;
                    tick_d  = '0;
                    bits_d  = '0;
                    data_d  = '0;
                    seen1_d = 1'b0;
                    pe_d    = 1'b0;
                    fre_d   = 1'b0;
                    stopn_d = 1'b0;
                end
            end
            S_START: begin
                if (w_mid && w_vote) begin
                    state_d = S_IDLE;
                end else if (w_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    data_d[bits_q] = w_vote;
                    seen1_d        = seen1_q | w_vote;
                end
                if (w_end) begin
                    if (bits_q == ({1'b0, data_len} + 3'd4)) begin
                        state_d = parity_en ? S_PARITY : S_STOP;
                    end else begin
                        bits_d = bits_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_mid) begin
                    pe_d    = ((^data_q) ^ w_vote) != parity_type;
                    seen1_d = seen1_q | w_vote;
                end else if (w_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_mid) begin
                    if (!stopn_q && !seen1_q && !w_vote) begin
                        w_push       = 1'b1;
                        w_push_entry = {1'b1, 1'b1, 1'b0, 8'h00};
                        state_d      = S_BRKWAIT;
                    end else if (stop2 && !stopn_q) begin
                        fre_d = fre_q | ~w_vote;
                    end else begin
                        w_push       = 1'b1;
                        w_push_entry = {1'b0, fre_q | ~w_vote, pe_q, data_q};
                        state_d      = S_IDLE;
                    end
                end else if (w_end) begin
                    stopn_d = 1'b1;
                end
            end
            S_BRKWAIT: begin
                if (bclk && w_rxd) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rx_en && state_q != S_IDLE) begin
            state_d = S_IDLE;
            w_push  = 1'b0;
        end
    end

    assign rx_bclk_en = (state_q != S_IDLE);

    logic [10:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic [10:0] hold_q;
    logic        ov_q;
    logic [AW:0] w_level, w_thr_lvl;
    logic        w_empty, w_full, w_pop, w_wr, w_ovf;
    logic [10:0] w_head;

    assign w_level = wr_q - rd_q;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = read_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovf   = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem_q[wr_q[AW-1:0]] <= w_push_entry;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q   <= '0;
            rd_q   <= '0;
            hold_q <= '0;
            ov_q   <= 1'b0;
        end else begin
            if (w_wr) wr_q <= wr_q + (AW+1)'(1);
            if (w_pop) begin
                rd_q   <= rd_q + (AW+1)'(1);
                hold_q <= mem_q[rd_q[AW-1:0]];
            end
            if (w_ovf) begin
                ov_q <= 1'b1;
            end else if (read_en) begin
                ov_q <= 1'b0;
            end
        end
    end

    always_comb begin
        w_thr_lvl = (AW+1)'(1);
        case (rx_thr_val)
            2'b00:   w_thr_lvl = (AW+1)'(1);
            2'b01:   w_thr_lvl = (AW+1)'(FIFO_DEPTH/4);
            2'b10:   w_thr_lvl = (AW+1)'(FIFO_DEPTH/2);
            default: w_thr_lvl = (AW+1)'(FIFO_DEPTH-2);
        endcase
    end

    // When empty, the last popped entry stays visible.
    assign w_head   = w_empty ? hold_q : mem_q[rd_q[AW-1:0]];
    assign data_out = w_head[7:0];
    assign rx_pe    = w_head[8];
    assign rx_fre   = w_head[9];
    assign rx_brk   = w_head[10];
    assign rx_ov    = ov_q;
    assign rx_thr   = (w_level >= w_thr_lvl);
    assign rx_empty = w_empty;
    assign rx_level = w_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : table-driven frame vectors plus scoreboarded sequences
// Revision        : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int OVS = 16;
    localparam int NV  = 9;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       bclk = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_en = 1'b0;
    logic       read_en = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic [1:0] data_len = 2'b11;
    logic       stop2 = 1'b0;
    logic [1:0] rx_thr_val = 2'b00;
    logic [7:0] data_out;
    logic       rx_fre, rx_pe, rx_brk, rx_ov, rx_thr, rx_empty, rx_bclk_en;
    logic [4:0] rx_level;

    int          checks = 0;
    int          failures = 0;
    logic [10:0] sb[$];

    typedef struct {
        logic [7:0]  data;
        int          nbits;
        logic        pen;
        logic        podd;
        logic        pbad;
        logic        two;
        logic        s1;
        logic        s2;
        logic [10:0] exp;
    } vec_t;
    vec_t v[NV];

    uart_rx_fifo #(.OVS(16), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .bclk(bclk), .rxd(rxd), .rx_en(rx_en),
        .read_en(read_en), .parity_en(parity_en), .parity_type(parity_type),
        .data_len(data_len), .stop2(stop2), .rx_thr_val(rx_thr_val),
        .data_out(data_out), .rx_fre(rx_fre), .rx_pe(rx_pe), .rx_brk(rx_brk),
        .rx_ov(rx_ov), .rx_thr(rx_thr), .rx_empty(rx_empty), .rx_level(rx_level),
        .rx_bclk_en(rx_bclk_en)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        rxd = b;
        repeat (OVS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic pbad,
                              input logic s1, input logic s2);
        logic p;
        p = parity_type ^ pbad;
        bit_time(1'b0);
        for (int b = 0; b < nbits; b++) begin
            p = p ^ d[b];
            bit_time(d[b]);
        end
        if (parity_en) bit_time(p);
        bit_time(s1);
        if (stop2) bit_time(s2);
        rxd = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [10:0] exp;
        int n;
        n = 0;
        while (rx_empty && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (rx_empty) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout, rx_empty=1 required 0", name);
        end else if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected entry 0x%0h, required none", name, data_out);
        end else begin
            exp = sb.pop_front();
            check(name, {21'd0, rx_brk, rx_fre, rx_pe, data_out}, {21'd0, exp});
            read_en = 1'b1;
            @(negedge clk);
            read_en = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {17'd0, data_out, rx_fre, rx_pe, rx_brk, rx_ov, rx_thr, rx_empty, rx_bclk_en},
              {17'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        check({name, "_level"}, rx_level, 0);
    endtask

    initial begin
        v[0] = '{8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {3'b000, 8'h55}};
        v[1] = '{8'h2A, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, {3'b001, 8'h2A}};
        v[2] = '{8'h11, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, {3'b000, 8'h11}};
        v[3] = '{8'hA3, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {3'b010, 8'hA3}};
        v[4] = '{8'hE7, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {3'b000, 8'h07}};
        v[5] = '{8'h3C, 6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {3'b000, 8'h3C}};
        v[6] = '{8'h80, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {3'b010, 8'h80}};
        v[7] = '{8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, {3'b000, 8'h00}};
        v[8] = '{8'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {3'b011, 8'h5A}};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        rx_en  = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            parity_en   = v[i].pen;
            parity_type = v[i].podd;
            data_len    = 2'(v[i].nbits - 5);
            stop2       = v[i].two;
            sb.push_back(v[i].exp);
            send_frame(v[i].data, v[i].nbits, v[i].pbad, v[i].s1, v[i].s2);
            check($sformatf("vec%0d_level", i), rx_level, 1);
            pop_check($sformatf("vec%0d_head", i));
            check($sformatf("vec%0d_empty_after_pop", i), rx_empty, 1);
        end

        // False start: short low glitch while idle
        parity_en = 1'b1; parity_type = 1'b0; data_len = 2'b11; stop2 = 1'b0;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", rx_bclk_en, 1);
        repeat (40) @(negedge clk);
        check("glitch_idle", rx_bclk_en, 0);
        check("glitch_no_entry", rx_level, 0);

        // Break: line low for two frame times
        rxd = 1'b0;
        repeat (2 * 11 * OVS) @(negedge clk);
        sb.push_back({3'b110, 8'h00});
        rxd = 1'b1;
        repeat (3 * OVS) @(negedge clk);
        check("brk_level", rx_level, 1);
        check("brk_idle", rx_bclk_en, 0);
        repeat (11 * OVS) @(negedge clk);
        check("brk_no_more", rx_level, 1);
        pop_check("brk_head");

        // Overflow: 17 frames, no reads
        parity_en = 1'b0; stop2 = 1'b0; rx_thr_val = 2'b11;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb.push_back({3'b000, 8'(i)});
            send_frame(8'(i), 8, 1'b0, 1'b1, 1'b1);
        end
        check("ovf_level", rx_level, 16);
        check("ovf_flag", rx_ov, 1);
        check("ovf_head", data_out, 8'h00);
        check("ovf_thr", rx_thr, 1);
        for (int i = 0; i < 16; i++) begin
            pop_check($sformatf("ovf_pop%0d", i));
            if (i == 0) check("ovf_cleared", rx_ov, 0);
        end
        check("drain_last", data_out, 8'h0F);
        check("drain_empty", rx_empty, 1);
        check("drain_ov", rx_ov, 0);
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        check("empty_read_hold", data_out, 8'h0F);
        check("empty_read_level", rx_level, 0);

        // Threshold at DEPTH/2
        rx_thr_val = 2'b10;
        for (int i = 0; i < 7; i++) begin
            sb.push_back({3'b000, 8'(8'h40 + i)});
            send_frame(8'(8'h40 + i), 8, 1'b0, 1'b1, 1'b1);
        end
        check("thr7_level", rx_level, 7);
        check("thr7", rx_thr, 0);
        sb.push_back({3'b000, 8'h47});
        send_frame(8'h47, 8, 1'b0, 1'b1, 1'b1);
        check("thr8", rx_thr, 1);

        // Receiver disabled mid-frame: partial frame dropped, FIFO kept
        rxd = 1'b0;
        repeat (3 * OVS) @(negedge clk);
        check("rxen_busy", rx_bclk_en, 1);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rxen_abort", rx_bclk_en, 0);
        rxd = 1'b1;
        repeat (10 * OVS) @(negedge clk);
        rx_en = 1'b1;
        repeat (OVS) @(negedge clk);
        check("rxen_level_kept", rx_level, 8);
        check("rxen_head_kept", data_out, 8'h40);

        // Asynchronous reset mid-frame
        rxd = 1'b0;
        repeat (3 * OVS) @(negedge clk);
        check("rst_busy", rx_bclk_en, 1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        rxd = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        parity_en = 1'b1; parity_type = 1'b0;
        sb.push_back({3'b000, 8'hC4});
        send_frame(8'hC4, 8, 1'b0, 1'b1, 1'b1);
        pop_check("post_reset_head");
        check("post_reset_empty", rx_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver with an oversampled, majority-voted bit recovery FSM and an on-chip receive FIFO. It supports configurable character length, optional parity, one or two stop bits, and break detection, with per-entry error flags. It sits between the baud generator (bclk tick) and the peripheral register/interrupt logic, and raises a programmable FIFO-level threshold flag.

Parameters:
OVS, 16, oversample ticks per bit; even, ≥8.
FIFO_DEPTH, 16, receive FIFO entries; power of 2, ≥4.
SYNC_STAGES, 2, rxd synchroniser flops; ≥2.

Ports:
clk  input  1  system clock
resetn  input  1  reset; one clock, reset is asynchronous and active-low
bclk  input  1  oversample tick, single-clk-cycle enable at OVS×baud
rxd  input  1  serial line, asynchronous, idle high
rx_en  input  1  receiver enable
read_en  input  1  pop FIFO head (one entry per cycle asserted)
parity_en  input  1  parity bit present/checked
parity_type  input  1  0=even, 1=odd
data_len  input  2  00=5, 01=6, 10=7, 11=8 data bits
stop2  input  1  two stop bits
rx_thr_val  input  2  threshold: 00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
data_out  output  8  FIFO head data; unused high bits zero
rx_fre  output  1  head entry frame error
rx_pe  output  1  head entry parity error
rx_brk  output  1  head entry is a break
rx_ov  output  1  sticky overflow
rx_thr  output  1  level ≥ threshold
rx_empty  output  1  FIFO empty
rx_level  output  $clog2(FIFO_DEPTH)+1  entries held
rx_bclk_en  output  1  receiver busy (FSM not IDLE); gates baud generator

Behaviour:
- Reset: FSM=IDLE, FIFO empty; data_out=0, rx_fre=rx_pe=rx_brk=rx_ov=rx_thr=0, rx_empty=1, rx_level=0, rx_bclk_en=0. Synchroniser flops reset to 1.
- All FSM activity advances only on cycles with bclk=1. The tick counter runs 0..OVS-1 per bit.
- Bit value = majority of samples at ticks OVS/2-1, OVS/2, OVS/2+1.
- States:
  - IDLE: falling edge on synced rxd with rx_en=1 → START, tick counter cleared.
  - START: at mid-bit, voted 1 = false start → IDLE; else at tick OVS-1 → DATA.
  - DATA: bits are received LSB first, count = data_len+5; then → PARITY if parity_en, else → STOP.
  - PARITY: check XOR(data, parity bit) against parity_type (even expects 0).
  - STOP: voted 0 sets fre. If stop2, a second STOP bit is checked identically (either 0 sets fre). The frame completes at mid-sample of the final stop bit; no wait for bit end.
  - BRKWAIT: entered if a break is detected; stays until synced rxd=1, then → IDLE.
- Break: all data bits, parity (if enabled), and first stop bit sampled 0 → entry {brk=1, fre=1, pe=0, data=0}, then BRKWAIT.
- Push: the entry {brk, fre, pe, data} is written on the completing tick cycle. It appears on data_out/flags the next clk cycle (first-word fall-through), and rx_empty falls in that same cycle.
- Pop: read_en with rx_empty=0 advances the head next cycle. read_en on empty is ignored, and outputs remain at the last values.
- Push when full: the entry is dropped and rx_ov is set.
- Push and pop in the same cycle while full: both occur, level is unchanged, and there is no overflow.
- rx_ov is sticky. It is cleared on any cycle with read_en=1 when no new overflow occurs that cycle; set has priority.
- rx_thr is combinational from rx_level vs the selected threshold.
- rx_en deasserted mid-frame: FSM → IDLE next clk, partial frame discarded, FIFO contents kept. Config inputs must be stable while rx_bclk_en=1; changes mid-frame are undefined.
- rx_level wraps never: saturates at FIFO_DEPTH by construction, with FIFO pointers one bit wider than the address.

Test Plan:
- Set OVS=16, bclk=1 every clk, 8 bits, even parity. Send 0x55 with parity 0 and stop 1 → data_out=0x55, rx_pe=0, rx_fre=0, rx_empty=0, rx_level=1.
- Use odd parity and 7 bits. Send 0x2A with a wrong parity bit → data_out=0x2A, rx_pe=1. A following correct frame 0x11 → second entry has pe=0 after the pop.
- Set stop2=1 and send 0xA3 with the second stop bit=0 → rx_fre=1, data_out=0xA3. Put a 4-tick low glitch on rxd in idle → no entry (false start), rx_bclk_en returns to 0.
- Hold rxd low for 2 frame times, then high → one entry with rx_brk=1, rx_fre=1, data_out=0x00. No further entries until the next start bit.
- With FIFO_DEPTH=16 and no reads, send 17 frames 0x00..0x10 → rx_level=16, rx_ov=1, head=0x00. Pop all 16 → last data 0x0F, rx_empty=1, rx_ov=0.
- Set rx_thr_val=10 and send 7 frames → rx_thr=0; the 8th → rx_thr=1. Deassert resetn mid-frame → all outputs at reset values immediately, and the FIFO is empty.
